mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of BUSY cycles to wait for m_ack before aborting (range 1..255).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction-fetch request.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetch read data.
- i_ack  out  1  fetch completion pulse.
- i_err  out  1  fetch timeout flag, valid with i_ack.
- d_req  in  1  data request.
- d_we  in  1  data write enable.
- d_be  in  DATA_W/8  byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  data read data.
- d_ack  out  1  data completion pulse.
- d_err  out  1  data timeout flag, valid with d_ack.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_be  out  DATA_W/8  memory byte enables.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data.
- m_ack  in  1  memory completion, one cycle.

Function
REQ-005 The FSM SHALL have states IDLE, BUSY_I, BUSY_D and RESP; all outputs SHALL be registered.
REQ-006 In IDLE, a grant SHALL follow these rules:
- d_req only: go to BUSY_D.
- i_req only: go to BUSY_I.
- both: grant the port not granted last (round-robin bit last_d), then go to BUSY_x.
- neither: stay in IDLE.
REQ-007 On the grant edge, the block SHALL latch the granted port's address, we, be and wdata into the m_* registers and set m_req=1.
- Fetch grants SHALL drive m_we=0, m_be all ones and m_wdata=0.
REQ-008 In BUSY_x, m_req and all m_* outputs SHALL hold stable until m_ack=1 is sampled or the timeout fires.
- Requester inputs SHALL be ignored after the grant.
REQ-009 On the edge where m_ack=1 in BUSY_x, the block SHALL:
- clear m_req;
- capture m_rdata into x_rdata, or 0 if the transaction was a write;
- set x_ack=1 and x_err=0;
- update last_d;
- enter RESP.
REQ-010 RESP SHALL last exactly one cycle, with x_ack=1 for exactly that cycle; the next edge SHALL clear x_ack and x_err and return to IDLE.
REQ-011 Requesters SHALL hold x_req and their operands until x_ack is seen, and SHALL drop or replace the request in the cycle after x_ack.
- Because RESP returns to IDLE only after one cycle, the block SHALL never re-grant the completed request.
REQ-012 Minimum latency SHALL be: request seen in IDLE at cycle 0, m_req at cycle 1, m_ack at cycle 1, x_ack at cycle 2, IDLE at cycle 3.
REQ-013 An 8-bit wait counter SHALL clear on every grant and increment each BUSY cycle without m_ack.
- When the counter reaches TIMEOUT, the block SHALL clear m_req, set x_ack=1, x_err=1 and x_rdata=0, update last_d, and enter RESP.
REQ-014 m_ack SHALL be ignored in IDLE and RESP, and SHALL NOT produce an ack.
REQ-015 If m_ack=1 on the same edge the counter reaches TIMEOUT, m_ack SHALL win (err=0, data captured).
REQ-016 i_ack and d_ack SHALL never be high in the same cycle, and at most one transaction SHALL be outstanding.
REQ-017 Under continuous requests from both ports, grants SHALL strictly alternate D,I,D,I...

Reset
REQ-018 Asserting reset SHALL immediately, without waiting for clk, force:
- state=IDLE;
- m_req=0, m_we=0, m_be=0, m_addr=0, m_wdata=0;
- i_ack=0, d_ack=0, i_err=0, d_err=0;
- i_rdata=0, d_rdata=0;
- wait counter=0;
- last_d=0, so data wins the first contention.
REQ-019 Reset during BUSY or RESP SHALL abandon the transaction with no ack, and a later m_ack SHALL be ignored.
REQ-020 The first grant after reset SHALL be evaluated on the first rising clk edge after reset deasserts.

Verification
REQ-021 The bench SHALL cover a single fetch: i_req=1, i_addr=0x00400000; memory acks 1 cycle after m_req with m_rdata=0x8C080004 -> m_addr=0x00400000, m_we=0; i_ack one cycle with i_rdata=0x8C080004, i_err=0.
REQ-022 The bench SHALL cover contention: i_req and d_req both high from reset release with immediate m_ack -> grant order D,I,D,I; i_ack and d_ack never coincide.
REQ-023 The bench SHALL cover a data write: d_we=1, d_be=4'b0011, d_addr=0x10010000, d_wdata=0xDEADBEEF; m_ack after 3 cycles -> m_* stable for 3 cycles; d_ack=1, d_rdata=0, d_err=0.
REQ-024 The bench SHALL cover timeout: TIMEOUT=4, d_req=1, m_ack never asserted -> m_req high exactly 4 cycles, then d_ack=1, d_err=1, d_rdata=0; a following fetch completes normally.
REQ-025 The bench SHALL cover reset mid-transaction: reset pulsed during BUSY_D, then m_ack=1 pulsed in IDLE -> all outputs 0, no ack; the next d_req is granted normally.
REQ-026 The bench SHALL cover the m_ack/timeout tie: m_ack=1 on the timeout cycle -> x_err=0, data captured.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Two-port (instruction fetch / data) round-robin arbiter onto a single memory port,
// one outstanding transaction, with a bounded wait for m_ack and registered outputs.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                d_err,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ack,
    output logic [1:0]          dbg_state
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [7:0] TO = 8'(TIMEOUT);

    // Handshake: a requester raises x_req with stable operands and holds them until it
    // sees the one-cycle x_ack pulse; memory answers a held m_req with a one-cycle m_ack.
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    state_t              state, state_nx;
    logic                m_req_nx, m_we_nx;
    logic [BE_W-1:0]     m_be_nx;
    logic [ADDR_W-1:0]   m_addr_nx;
    logic [DATA_W-1:0]   m_wdata_nx;
    logic [DATA_W-1:0]   i_rdata_nx, d_rdata_nx;
    logic                i_ack_nx, i_err_nx, d_ack_nx, d_err_nx;
    logic [7:0]          cnt, cnt_nx;
    logic                last_d, last_d_nx;
    logic                timed_out;

    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_be    <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            i_ack   <= 1'b0;
            i_err   <= 1'b0;
            d_rdata <= '0;
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
            cnt     <= '0;
            last_d  <= 1'b0;
        end else begin
            state   <= state_nx;
            m_req   <= m_req_nx;
            m_we    <= m_we_nx;
            m_be    <= m_be_nx;
            m_addr  <= m_addr_nx;
            m_wdata <= m_wdata_nx;
            i_rdata <= i_rdata_nx;
            i_ack   <= i_ack_nx;
            i_err   <= i_err_nx;
            d_rdata <= d_rdata_nx;
            d_ack   <= d_ack_nx;
            d_err   <= d_err_nx;
            cnt     <= cnt_nx;
            last_d  <= last_d_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        m_req_nx   = m_req;
        m_we_nx    = m_we;
        m_be_nx    = m_be;
        m_addr_nx  = m_addr;
        m_wdata_nx = m_wdata;
        i_rdata_nx = i_rdata;
        i_ack_nx   = i_ack;
        i_err_nx   = i_err;
        d_rdata_nx = d_rdata;
        d_ack_nx   = d_ack;
        d_err_nx   = d_err;
        cnt_nx     = cnt;
        last_d_nx  = last_d;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                // Data wins contention unless it was the last port served.
                if (d_req && (!i_req || !last_d)) begin
                    state_nx   = BUSY_D;
                    m_req_nx   = 1'b1;
                    m_we_nx    = d_we;
                    m_be_nx    = d_be;
                    m_addr_nx  = d_addr;
                    m_wdata_nx = d_wdata;
                    cnt_nx     = '0;
                end else if (i_req) begin
                    state_nx   = BUSY_I;
                    m_req_nx   = 1'b1;
                    m_we_nx    = 1'b0;
                    m_be_nx    = '1;
                    m_addr_nx  = i_addr;
                    m_wdata_nx = '0;
                    cnt_nx     = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                // A late m_ack on the timeout edge still completes the transaction.
                if (m_ack || (cnt + 8'd1 == TO)) begin
                    timed_out = !m_ack;
                    state_nx  = RESP;
                    m_req_nx  = 1'b0;
                    last_d_nx = (state == BUSY_D);
                    if (state == BUSY_D) begin
                        d_ack_nx   = 1'b1;
                        d_err_nx   = timed_out;
                        d_rdata_nx = (timed_out || m_we) ? '0 : m_rdata;
                    end else begin
                        i_ack_nx   = 1'b1;
                        i_err_nx   = timed_out;
                        i_rdata_nx = timed_out ? '0 : m_rdata;
                    end
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            RESP: begin
                state_nx = IDLE;
                i_ack_nx = 1'b0;
                i_err_nx = 1'b0;
                d_ack_nx = 1'b0;
                d_err_nx = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_arbiter: requester driver, memory responder model,
// response scoreboard per port, grant-order log and bus-stability monitor.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 4;

    logic          clk, reset;
    logic          i_req, i_ack, i_err;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_ack, d_err;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_req, m_we, m_ack;
    logic [BW-1:0] m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // memory model controls: mem_delay = cycles of m_req before m_ack (0 = never)
    int            mem_delay = 1;
    logic [DW-1:0] mem_key = '0;
    logic          mem_force_ack = 1'b0;

    logic [DW:0]           exp_i_q[$];
    logic [DW:0]           exp_d_q[$];
    logic [AW-1:0]         i_cmd_q[$];
    logic [1+BW+AW+DW-1:0] d_cmd_q[$];
    logic                  gnt_log[$];

    logic [1+BW+AW+DW-1:0] hold_ref;
    logic [DW:0]           mon_e;
    logic                  prev_m_req, prev_i_ack, prev_d_ack;
    int                    busy_len, last_busy_len;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW:0] expect_rsp(input logic we, input logic [AW-1:0] addr);
        if (mem_delay == 0 || mem_delay > TO) return {1'b1, {DW{1'b0}}};
        if (we) return {1'b0, {DW{1'b0}}};
        return {1'b0, addr ^ mem_key};
    endfunction

    // memory responder
    initial begin
        int mcnt;
        mcnt = 0;
        m_ack = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if (m_req) mcnt++;
            else mcnt = 0;
            if ((m_req && mcnt == mem_delay) || mem_force_ack) begin
                m_ack = 1'b1;
                m_rdata = m_addr ^ mem_key;
            end
        end
    end

    // scoreboard / monitor
    initial begin
        prev_m_req = 1'b0;
        prev_i_ack = 1'b0;
        prev_d_ack = 1'b0;
        busy_len = 0;
        last_busy_len = 0;
        forever begin
            @(negedge clk);
            check("ack_excl", i_ack & d_ack, 1'b0);
            if (i_ack) begin
                check("i_ack_pulse", prev_i_ack, 1'b0);
                if (exp_i_q.size() == 0) check("i_ack_unexp", i_ack, 1'b0);
                else begin
                    mon_e = exp_i_q.pop_front();
                    check("i_rsp", {i_err, i_rdata}, mon_e);
                end
            end
            if (d_ack) begin
                check("d_ack_pulse", prev_d_ack, 1'b0);
                if (exp_d_q.size() == 0) check("d_ack_unexp", d_ack, 1'b0);
                else begin
                    mon_e = exp_d_q.pop_front();
                    check("d_rsp", {d_err, d_rdata}, mon_e);
                end
            end
            if (m_req) begin
                if (!prev_m_req) begin
                    gnt_log.push_back(m_addr[28]);
                    if (m_addr[28]) hold_ref = {d_we, d_be, d_addr, d_wdata};
                    else hold_ref = {1'b0, {BW{1'b1}}, i_addr, {DW{1'b0}}};
                    busy_len = 0;
                end
                busy_len++;
                check("m_hold", {m_we, m_be, m_addr, m_wdata}, hold_ref);
            end else if (prev_m_req) begin
                last_busy_len = busy_len;
            end
            prev_m_req = m_req;
            prev_i_ack = i_ack;
            prev_d_ack = d_ack;
        end
    end

    // driver tasks
    task automatic push_i(input logic [AW-1:0] addr);
        i_cmd_q.push_back(addr);
        exp_i_q.push_back(expect_rsp(1'b0, addr));
    endtask

    task automatic push_d(input logic we, input logic [BW-1:0] be,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        d_cmd_q.push_back({we, be, addr, wdata});
        exp_d_q.push_back(expect_rsp(we, addr));
    endtask

    task automatic load();
        if (!i_req && i_cmd_q.size() > 0) begin
            i_addr = i_cmd_q.pop_front();
            i_req = 1'b1;
        end
        if (!d_req && d_cmd_q.size() > 0) begin
            {d_we, d_be, d_addr, d_wdata} = d_cmd_q.pop_front();
            d_req = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        if (i_ack) i_req = 1'b0;
        if (d_ack) d_req = 1'b0;
        load();
    endtask

    function automatic logic all_done();
        return i_cmd_q.size() == 0 && d_cmd_q.size() == 0 && !i_req && !d_req &&
               exp_i_q.size() == 0 && exp_d_q.size() == 0;
    endfunction

    task automatic run(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!all_done() && n < budget);
        check("run_done", all_done(), 1'b1);
        if (!all_done()) begin
            i_cmd_q.delete();
            d_cmd_q.delete();
            exp_i_q.delete();
            exp_d_q.delete();
            i_req = 1'b0;
            d_req = 1'b0;
        end
    endtask

    task automatic check_reset_state();
        check("rst_rsp", {i_rdata, i_ack, i_err, d_rdata, d_ack, d_err}, '0);
        check("rst_mem", {m_req, m_we, m_be, m_addr, m_wdata}, '0);
        check("rst_state", dbg_state, 2'd0);
    endtask

    initial begin
        logic [31:0] r;
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;

        // single fetch, one-cycle memory
        mem_key = 32'h8C480004;
        mem_delay = 1;
        push_i(32'h00400000);
        run(50);
        check("fetch_len", last_busy_len, 1);

        // data write, three-cycle memory
        mem_delay = 3;
        push_d(1'b1, 4'b0011, 32'h10010000, 32'hDEADBEEF);
        run(50);
        check("write_len", last_busy_len, 3);

        // timeout, then a normal fetch
        mem_delay = 0;
        push_d(1'b0, 4'hF, 32'h10010040, 32'h0);
        run(50);
        check("tmo_len", last_busy_len, TO);
        mem_delay = 1;
        push_i(32'h00400010);
        run(50);
        check("post_tmo_len", last_busy_len, 1);

        // m_ack on the timeout edge
        mem_delay = TO;
        mem_key = 32'h13572468;
        push_d(1'b0, 4'hF, 32'h10010080, 32'h0);
        run(50);
        check("tie_len", last_busy_len, TO);

        // contention from reset release
        reset = 1'b1;
        mem_delay = 1;
        mem_key = 32'hA5A5_0F0F;
        gnt_log.delete();
        for (int k = 0; k < 3; k++) begin
            push_d(1'b0, 4'hF, 32'h10010100 + 32'(4 * k), 32'h0);
            push_i(32'h00400100 + 32'(4 * k));
        end
        @(negedge clk);
        #1;
        load();
        @(negedge clk);
        #1;
        reset = 1'b0;
        run(100);
        check("gnt_count", gnt_log.size(), 6);
        for (int k = 0; k < 6 && k < gnt_log.size(); k++)
            check("gnt_order", gnt_log[k], (k % 2 == 0) ? 1'b1 : 1'b0);

        // reset in BUSY_D, stray m_ack in IDLE
        mem_delay = 0;
        d_cmd_q.push_back({1'b1, 4'hF, 32'h10010200, 32'h12345678});
        repeat (3) step();
        check("pre_rst_state", dbg_state, 2'd2);
        reset = 1'b1;
        #1;
        check_reset_state();
        d_req = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        mem_force_ack = 1'b1;
        step();
        mem_force_ack = 1'b0;
        step();
        check("stray_ack", {i_ack, d_ack, m_req}, 3'b000);
        check("stray_state", dbg_state, 2'd0);
        mem_delay = 1;
        push_d(1'b0, 4'hF, 32'h10010300, 32'h0);
        run(50);
        check("post_rst_len", last_busy_len, 1);

        // random single transactions
        for (int k = 0; k < 8; k++) begin
            mem_delay = $urandom_range(1, 3);
            mem_key = $urandom;
            r = $urandom;
            if ($urandom_range(0, 1) == 1)
                push_i({12'h004, r[19:2], 2'b00});
            else
                push_d(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       {12'h100, r[19:2], 2'b00}, $urandom);
            run(50);
            check("rand_len", last_busy_len, mem_delay);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
